lock_ctrl: RTL

LOCK_CTRL -- requirements
Module: lock_ctrl

---
 rtl/lock_pkg.sv | 25 ++
 rtl/btn_debounce.sv | 44 ++++
 rtl/lock_ctrl.sv | 135 +++++++++++++
 3 files changed

// File: rtl/lock_pkg.sv
// Shared types and default timing constants for the lock controller.
package lock_pkg;

  typedef enum logic [2:0] {
    ST_CLEAR    = 3'd0,
    ST_IDLE     = 3'd1,
    ST_ENTRY    = 3'd2,
    ST_UNLOCKED = 3'd3,
    ST_LOCKOUT  = 3'd4
  } state_t;

  localparam logic [15:0] DEF_DEBOUNCE  = 16'd50000;
  localparam logic [23:0] DEF_TIMEOUT   = 24'd5000000;
  localparam logic [23:0] DEF_HOLD      = 24'd10000000;
  localparam logic [23:0] DEF_LOCKOUT   = 24'd15000000;
  localparam logic [1:0]  DEF_MAX_FAILS = 2'd3;

  function automatic logic [1:0] sat_inc(
    input logic [1:0] v,
    input logic [1:0] lim
  );
    return (v >= lim) ? lim : v + 2'd1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw button -> 2-flop sync -> debounced level -> one-cycle press event.
module btn_debounce
  import lock_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES = DEF_DEBOUNCE
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn_raw,
  output logic o_press
);

  logic        r_sync0;
  logic        r_sync1;
  logic        r_level;
  logic        r_level_d;
  logic [15:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync0   <= 1'b0;
      r_sync1   <= 1'b0;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_sync0   <= i_btn_raw;
      r_sync1   <= r_sync0;
      r_level_d <= r_level;
      // any sample matching the accepted level restarts the run
      if (r_sync1 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt >= DEBOUNCE_CYCLES - 16'd1) begin
        r_level <= r_sync1;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 16'd1;
      end
    end
  end

  assign o_press = r_level & ~r_level_d;

endmodule

// File: rtl/lock_ctrl.sv
// Supervisor around an external code-lock FSM: button conditioning,
// entry timeout, failure counting, unlock hold and lockout.
module lock_ctrl
  import lock_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES    = DEF_DEBOUNCE,
  parameter logic [23:0] TIMEOUT_CYCLES     = DEF_TIMEOUT,
  parameter logic [23:0] UNLOCK_HOLD_CYCLES = DEF_HOLD,
  parameter logic [23:0] LOCKOUT_CYCLES     = DEF_LOCKOUT,
  parameter logic [1:0]  MAX_FAILS          = DEF_MAX_FAILS
) (
  input  logic       clk,
  input  logic       RST_BTN_N,
  input  logic       btn0_raw,
  input  logic       btn1_raw,
  input  logic       lock_led,
  input  logic [3:0] lock_bcd,
  output logic       btn0_pulse,
  output logic       btn1_pulse,
  output logic       lock_rst,
  output logic       unlocked,
  output logic       locked_out,
  output logic [1:0] fail_cnt
);

  state_t      r_state;
  state_t      w_next;
  logic [23:0] r_timer;
  logic [1:0]  r_fail_cnt;
  logic [1:0]  w_fail_nxt;
  logic [1:0]  w_fail_inc;
  logic [3:0]  r_bcd_prev;
  logic        r_p0;
  logic        r_p1;
  logic        w_ev0;
  logic        w_ev1;
  logic        w_any_ev;
  logic        w_both;
  logic        w_tmo;
  logic        w_hold_hit;
  logic        w_lo_hit;
  logic        w_fail;
  logic        w_strobe_ok;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db0 (
    .i_clk    (clk),
    .i_rst_n  (RST_BTN_N),
    .i_btn_raw(btn0_raw),
    .o_press  (w_ev0)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db1 (
    .i_clk    (clk),
    .i_rst_n  (RST_BTN_N),
    .i_btn_raw(btn1_raw),
    .o_press  (w_ev1)
  );

  assign w_any_ev    = w_ev0 | w_ev1;
  assign w_both      = w_ev0 & w_ev1;
  assign w_strobe_ok = (r_state == ST_IDLE) | (r_state == ST_ENTRY);
  assign w_tmo       = ~w_any_ev & (r_timer >= TIMEOUT_CYCLES - 24'd1);
  assign w_hold_hit  = r_timer >= UNLOCK_HOLD_CYCLES - 24'd1;
  assign w_lo_hit    = r_timer >= LOCKOUT_CYCLES - 24'd1;
  assign w_fail_inc  = sat_inc(r_fail_cnt, MAX_FAILS);
  assign w_fail      = ((r_bcd_prev != 4'd0) & (lock_bcd == 4'd0))
                     | w_tmo | w_both;

  always_comb begin
    w_next     = r_state;
    w_fail_nxt = r_fail_cnt;
    case (r_state)
      ST_CLEAR: w_next = ST_IDLE;
      ST_IDLE: begin
        if (lock_bcd != 4'd0) w_next = ST_ENTRY;
      end
      ST_ENTRY: begin
        // a same-cycle unlock beats any failure
        if (lock_led) begin
          w_next     = ST_UNLOCKED;
          w_fail_nxt = 2'd0;
        end else if (w_fail) begin
          w_fail_nxt = w_fail_inc;
          w_next     = (w_fail_inc >= MAX_FAILS) ? ST_LOCKOUT : ST_CLEAR;
        end
      end
      ST_UNLOCKED: begin
        if (w_hold_hit) w_next = ST_CLEAR;
      end
      ST_LOCKOUT: begin
        if (w_lo_hit) begin
          w_next     = ST_CLEAR;
          w_fail_nxt = 2'd0;
        end
      end
      default: w_next = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge RST_BTN_N) begin
    if (!RST_BTN_N) begin
      r_state    <= ST_CLEAR;
      r_timer    <= '0;
      r_fail_cnt <= '0;
      r_bcd_prev <= '0;
      r_p0       <= 1'b0;
      r_p1       <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_fail_cnt <= w_fail_nxt;
      r_bcd_prev <= lock_bcd;
      r_p0       <= w_ev0 & ~w_ev1 & w_strobe_ok;
      r_p1       <= w_ev1 & ~w_ev0 & w_strobe_ok;
      if (w_next != r_state) begin
        r_timer <= '0;
      end else if ((r_state == ST_ENTRY) && w_any_ev) begin
        r_timer <= '0;
      end else if (r_timer != '1) begin
        r_timer <= r_timer + 24'd1;
      end
    end
  end

  assign btn0_pulse = r_p0;
  assign btn1_pulse = r_p1;
  assign lock_rst   = (r_state == ST_CLEAR) | (r_state == ST_LOCKOUT);
  assign unlocked   = r_state == ST_UNLOCKED;
  assign locked_out = r_state == ST_LOCKOUT;
  assign fail_cnt   = r_fail_cnt;

endmodule
